nios2_cpu_debug_ocimem_arbiter: RTL and testbench

//  Sequences and arbitrates the CPU's on-chip debug memory (OCI RAM, 1-cycle read latency), sysclk domain.
//  Two requesters share the RAM:
//   - the CPU-side Avalon-MM debug slave;
//   - the JTAG-side commands decoded by the debug-slave sysclk block
//     (take_action_ocimem_a/b, take_no_action_ocimem_a, jdo).

---
 rtl/nios2_cpu_debug_ocimem_arbiter.sv | 202 ++++++++++++++++++++
 tb/tb_nios2_cpu_debug_ocimem_arbiter.sv | 398 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/nios2_cpu_debug_ocimem_arbiter.sv
// ---------------------------------------------------------------------------
// nios2_cpu_debug_ocimem_arbiter
//
// Shares the single-port OCI debug RAM (1-cycle read latency) between the
// CPU-side Avalon-MM debug slave and JTAG-side monitor commands. It also owns
// the JTAG monitor address/data registers (MonAReg/MonDReg).
//
// State table
//   state     | meaning
//   ----------+--------------------------------------------------------------
//   S_IDLE    | RAM free; arbitrate CPU vs pending JTAG op, issue strobe
//   S_CPU_RD  | CPU read data returning from RAM; completes Avalon read
//   S_JTAG_RD | JTAG read data returning from RAM; loads MonDReg, bumps MonAReg
//
// Ports
//   clk, reset                      system clock, synchronous active-high reset
//   av_*                            Avalon-MM debug slave (CPU requester)
//   take_action_ocimem_a/b,
//   take_no_action_ocimem_a, jdo    JTAG command strobes and data
//   ram_*                           OCI RAM interface (ram_rdata 1 clk after ram_rd)
//   MonDReg, MonAReg                JTAG monitor data / address registers
//   monitor_ready                   no JTAG op pending or in flight
//   jtag_overrun                    sticky: JTAG strobe arrived while busy
// ---------------------------------------------------------------------------
module nios2_cpu_debug_ocimem_arbiter #(
    parameter int ADDR_W = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic [ADDR_W-1:0] av_address,
    input  logic              av_read,
    input  logic              av_write,
    input  logic [31:0]       av_writedata,
    input  logic [3:0]        av_byteenable,
    output logic [31:0]       av_readdata,
    output logic              av_waitrequest,
    input  logic              take_action_ocimem_a,
    input  logic              take_action_ocimem_b,
    input  logic              take_no_action_ocimem_a,
    input  logic [37:0]       jdo,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_rd,
    output logic              ram_wr,
    output logic [31:0]       ram_wdata,
    output logic [3:0]        ram_be,
    input  logic [31:0]       ram_rdata,
    output logic [31:0]       MonDReg,
    output logic [ADDR_W-1:0] MonAReg,
    output logic              monitor_ready,
    output logic              jtag_overrun
);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CPU_RD  = 2'd1,
        S_JTAG_RD = 2'd2
    } state_t;

    state_t            state_q, state_d;
    logic              last_jtag_q, last_jtag_d;   // 1: last grant went to JTAG
    logic              pend_rd_q, pend_rd_d;
    logic              pend_wr_q, pend_wr_d;
    logic [ADDR_W-1:0] mon_a_q, mon_a_d;
    logic [31:0]       mon_d_q, mon_d_d;
    logic              overrun_q, overrun_d;

    logic jtag_busy;
    logic any_strobe;
    logic cpu_req;
    logic jtag_req;
    logic grant_cpu;
    logic grant_jtag;

    // jdo bits outside the address and data fields carry nothing for this block
    logic unused_jdo;
    assign unused_jdo = ^{jdo[37:35], jdo[1:0]};

    assign jtag_busy  = pend_rd_q | pend_wr_q | (state_q == S_JTAG_RD);
    assign any_strobe = take_action_ocimem_a | take_action_ocimem_b | take_no_action_ocimem_a;
    assign cpu_req    = av_read | av_write;
    assign jtag_req   = pend_rd_q | pend_wr_q;
    // Round-robin: on contention the side that did not win last time goes first
    assign grant_jtag = (state_q == S_IDLE) & jtag_req & (~cpu_req | ~last_jtag_q);
    assign grant_cpu  = (state_q == S_IDLE) & cpu_req & ~grant_jtag;

    always_comb begin
        state_d        = state_q;
        last_jtag_d    = last_jtag_q;
        pend_rd_d      = pend_rd_q;
        pend_wr_d      = pend_wr_q;
        mon_a_d        = mon_a_q;
        mon_d_d        = mon_d_q;
        overrun_d      = overrun_q;
        av_readdata    = '0;
        av_waitrequest = 1'b1;
        ram_addr       = '0;
        ram_rd         = 1'b0;
        ram_wr         = 1'b0;
        ram_wdata      = '0;
        ram_be         = '0;

        // JTAG capture. An accepted strobe implies no JTAG op is pending or in
        // flight, so the FSM below never touches the same registers this cycle.
        if (any_strobe) begin
            if (jtag_busy) begin
                overrun_d = 1'b1;
            end else if (take_action_ocimem_a) begin
                mon_a_d = jdo[ADDR_W+1:2];
                if (jdo[34]) begin
                    pend_rd_d = 1'b1;
                end
            end else if (take_action_ocimem_b) begin
                mon_d_d   = jdo[34:3];
                pend_wr_d = 1'b1;
            end else begin
                pend_rd_d = 1'b1;
            end
        end

        case (state_q)
            S_IDLE: begin
                if (grant_cpu) begin
                    last_jtag_d = 1'b0;
                    ram_addr    = av_address;
                    if (av_write) begin
                        ram_wr         = 1'b1;
                        ram_wdata      = av_writedata;
                        ram_be         = av_byteenable;
                        av_waitrequest = 1'b0;
                    end else begin
                        ram_rd  = 1'b1;
                        state_d = S_CPU_RD;
                    end
                end else if (grant_jtag) begin
                    last_jtag_d = 1'b1;
                    ram_addr    = mon_a_q;
                    if (pend_wr_q) begin
                        ram_wr    = 1'b1;
                        ram_wdata = mon_d_q;
                        ram_be    = 4'hF;
                        mon_a_d   = mon_a_q + ADDR_W'(1);
                        pend_wr_d = 1'b0;
                    end else begin
                        ram_rd    = 1'b1;
                        pend_rd_d = 1'b0;
                        state_d   = S_JTAG_RD;
                    end
                end
            end
            S_CPU_RD: begin
                av_readdata    = ram_rdata;
                av_waitrequest = 1'b0;
                state_d        = S_IDLE;
            end
            S_JTAG_RD: begin
                mon_d_d = ram_rdata;
                mon_a_d = mon_a_q + ADDR_W'(1);
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Reset cycle: abandon any completion and keep the RAM quiet
        if (reset) begin
            av_readdata    = '0;
            av_waitrequest = 1'b1;
            ram_addr       = '0;
            ram_rd         = 1'b0;
            ram_wr         = 1'b0;
            ram_wdata      = '0;
            ram_be         = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= S_IDLE;
            last_jtag_q <= 1'b0;
            pend_rd_q   <= 1'b0;
            pend_wr_q   <= 1'b0;
            mon_a_q     <= '0;
            mon_d_q     <= '0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            last_jtag_q <= last_jtag_d;
            pend_rd_q   <= pend_rd_d;
            pend_wr_q   <= pend_wr_d;
            mon_a_q     <= mon_a_d;
            mon_d_q     <= mon_d_d;
            overrun_q   <= overrun_d;
        end
    end

    assign MonAReg       = mon_a_q;
    assign MonDReg       = mon_d_q;
    assign jtag_overrun  = overrun_q;
    assign monitor_ready = ~(pend_rd_q | pend_wr_q) & (state_q != S_JTAG_RD);

endmodule

// File: tb/tb_nios2_cpu_debug_ocimem_arbiter.sv
// ---------------------------------------------------------------------------
// Testbench for nios2_cpu_debug_ocimem_arbiter.
// A transaction-level reference (outstanding-read owner, pending JTAG op,
// round-robin flag, reference memory image) predicts every output each cycle.
// Directed scenarios pin the reference with literal values; a random phase
// mixes CPU traffic, JTAG strobes (including overlapping ones) and resets.
// ---------------------------------------------------------------------------
module tb_nios2_cpu_debug_ocimem_arbiter;
    localparam int AW = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset;
    logic [AW-1:0] av_address;
    logic          av_read, av_write;
    logic [31:0]   av_writedata;
    logic [3:0]    av_byteenable;
    logic [31:0]   av_readdata;
    logic          av_waitrequest;
    logic          ta_a, ta_b, tna_a;
    logic [37:0]   jdo;
    logic [AW-1:0] ram_addr;
    logic          ram_rd, ram_wr;
    logic [31:0]   ram_wdata;
    logic [3:0]    ram_be;
    logic [31:0]   ram_rdata;
    logic [31:0]   MonDReg;
    logic [AW-1:0] MonAReg;
    logic          monitor_ready, jtag_overrun;

    nios2_cpu_debug_ocimem_arbiter #(.ADDR_W(AW)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .av_address              (av_address),
        .av_read                 (av_read),
        .av_write                (av_write),
        .av_writedata            (av_writedata),
        .av_byteenable           (av_byteenable),
        .av_readdata             (av_readdata),
        .av_waitrequest          (av_waitrequest),
        .take_action_ocimem_a    (ta_a),
        .take_action_ocimem_b    (ta_b),
        .take_no_action_ocimem_a (tna_a),
        .jdo                     (jdo),
        .ram_addr                (ram_addr),
        .ram_rd                  (ram_rd),
        .ram_wr                  (ram_wr),
        .ram_wdata               (ram_wdata),
        .ram_be                  (ram_be),
        .ram_rdata               (ram_rdata),
        .MonDReg                 (MonDReg),
        .MonAReg                 (MonAReg),
        .monitor_ready           (monitor_ready),
        .jtag_overrun            (jtag_overrun)
    );

    // OCI RAM environment, with a bench-side preload port
    logic [31:0] ram_mem [0:255];
    logic        ld_en;
    logic [7:0]  ld_addr;
    logic [31:0] ld_data;

    always @(posedge clk) begin
        if (ld_en) begin
            ram_mem[ld_addr] <= ld_data;
        end else if (ram_wr) begin
            for (int b = 0; b < 4; b++)
                if (ram_be[b]) ram_mem[ram_addr][8*b +: 8] <= ram_wdata[8*b +: 8];
        end
        if (ram_rd) ram_rdata <= ram_mem[ram_addr];
    end

    int n_pass  = 0;
    int n_total = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act !== exp)
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, exp, $time);
        else
            n_pass++;
    endtask

    // ---------------- reference model ----------------
    logic [31:0] ref_mem [0:255];
    bit          mvalid = 1'b0;
    bit          m_pend_rd, m_pend_wr, m_last_jtag, m_ovr;
    int          m_rd_owner;          // 0 none, 1 CPU read returning, 2 JTAG read returning
    logic [7:0]  m_mon_a, m_cpu_addr;
    logic [31:0] m_mon_d;
    bit          cpu_done;

    task automatic ref_write(input logic [7:0] a, input logic [31:0] d, input logic [3:0] be);
        for (int b = 0; b < 4; b++)
            if (be[b]) ref_mem[a][8*b +: 8] = d[8*b +: 8];
    endtask

    task automatic model_cycle();
        logic        e_wait, e_rd, e_wr, e_ready;
        logic [31:0] e_rdata, e_wdata;
        logic [7:0]  e_addr;
        logic [3:0]  e_be;
        bit          n_pend_rd, n_pend_wr, n_last_jtag, n_ovr, busy, cpu_req, jtag_req;
        int          n_owner;
        logic [7:0]  n_mon_a, n_cpu_addr;
        logic [31:0] n_mon_d;

        cpu_done = (av_read || av_write) && (av_waitrequest === 1'b0);
        e_wait = 1'b1; e_rd = 1'b0; e_wr = 1'b0;
        e_rdata = '0; e_wdata = '0; e_addr = '0; e_be = '0;
        e_ready = !(m_pend_rd || m_pend_wr) && (m_rd_owner != 2);
        n_pend_rd = m_pend_rd; n_pend_wr = m_pend_wr; n_last_jtag = m_last_jtag;
        n_ovr = m_ovr; n_owner = m_rd_owner; n_mon_a = m_mon_a; n_mon_d = m_mon_d;
        n_cpu_addr = m_cpu_addr;

        if (!reset && mvalid) begin
            busy = m_pend_rd || m_pend_wr || (m_rd_owner == 2);
            if (ta_a || ta_b || tna_a) begin
                if (busy) n_ovr = 1'b1;
                else if (ta_a) begin
                    n_mon_a = jdo[9:2];
                    if (jdo[34]) n_pend_rd = 1'b1;
                end else if (ta_b) begin
                    n_mon_d = jdo[34:3];
                    n_pend_wr = 1'b1;
                end else n_pend_rd = 1'b1;
            end
            if (m_rd_owner == 1) begin
                e_wait = 1'b0;
                e_rdata = ref_mem[m_cpu_addr];
                n_owner = 0;
            end else if (m_rd_owner == 2) begin
                n_mon_d = ref_mem[m_mon_a];
                n_mon_a = m_mon_a + 8'd1;
                n_owner = 0;
            end else begin
                cpu_req  = av_read || av_write;
                jtag_req = m_pend_rd || m_pend_wr;
                if (cpu_req && (!jtag_req || m_last_jtag)) begin
                    n_last_jtag = 1'b0;
                    e_addr = av_address;
                    if (av_write) begin
                        e_wr = 1'b1; e_wdata = av_writedata; e_be = av_byteenable; e_wait = 1'b0;
                        ref_write(av_address, av_writedata, av_byteenable);
                    end else begin
                        e_rd = 1'b1; n_owner = 1; n_cpu_addr = av_address;
                    end
                end else if (jtag_req) begin
                    n_last_jtag = 1'b1;
                    e_addr = m_mon_a;
                    if (m_pend_wr) begin
                        e_wr = 1'b1; e_wdata = m_mon_d; e_be = 4'hF;
                        ref_write(m_mon_a, m_mon_d, 4'hF);
                        n_mon_a = m_mon_a + 8'd1;
                        n_pend_wr = 1'b0;
                    end else begin
                        e_rd = 1'b1; n_pend_rd = 1'b0; n_owner = 2;
                    end
                end
            end
        end

        if (mvalid) begin
            chk("av_waitrequest", av_waitrequest, e_wait);
            chk("av_readdata", av_readdata, e_rdata);
            chk("ram_rd", ram_rd, e_rd);
            chk("ram_wr", ram_wr, e_wr);
            chk("ram_addr", ram_addr, e_addr);
            chk("ram_wdata", ram_wdata, e_wdata);
            chk("ram_be", ram_be, e_be);
            chk("MonAReg", MonAReg, m_mon_a);
            chk("MonDReg", MonDReg, m_mon_d);
            chk("monitor_ready", monitor_ready, e_ready);
            chk("jtag_overrun", jtag_overrun, m_ovr);
        end

        if (reset) begin
            m_pend_rd = 0; m_pend_wr = 0; m_last_jtag = 0; m_ovr = 0;
            m_rd_owner = 0; m_mon_a = '0; m_mon_d = '0; m_cpu_addr = '0;
            mvalid = 1'b1;
        end else if (mvalid) begin
            m_pend_rd = n_pend_rd; m_pend_wr = n_pend_wr; m_last_jtag = n_last_jtag;
            m_ovr = n_ovr; m_rd_owner = n_owner; m_mon_a = n_mon_a; m_mon_d = n_mon_d;
            m_cpu_addr = n_cpu_addr;
        end
    endtask

    // Inputs are set just after a negedge; outputs are judged 1 ns later.
    task automatic step();
        #1;
        model_cycle();
        @(negedge clk);
    endtask

    task automatic idle_in();
        av_read = 0; av_write = 0; av_address = '0; av_writedata = '0; av_byteenable = '0;
        ta_a = 0; ta_b = 0; tna_a = 0; jdo = '0;
    endtask

    initial begin
        int rd_cnt, j_gr, c_gr, viol, prev, owner, r;
        bit cpu_active;

        reset = 1'b1; ld_en = 1'b0; ld_addr = '0; ld_data = '0;
        idle_in();
        @(negedge clk);
        ld_en = 1'b1;
        for (int i = 0; i < 256; i++) begin
            ld_addr = 8'(i);
            ld_data = (i == 3) ? 32'hA5A50003 : $urandom;
            ref_mem[i] = ld_data;
            @(negedge clk);
        end
        ld_en = 1'b0;
        step();
        step();

        // reset state
        reset = 1'b0;
        #1;
        chk("rst_waitrequest", av_waitrequest, 1);
        chk("rst_monitor_ready", monitor_ready, 1);
        chk("rst_MonAReg", MonAReg, 0);
        chk("rst_MonDReg", MonDReg, 0);
        chk("rst_overrun", jtag_overrun, 0);
        chk("rst_ram_rd", ram_rd, 0);
        step();

        // 1: CPU write then read
        av_write = 1; av_address = 8'd5; av_writedata = 32'hDEADBEEF; av_byteenable = 4'hF;
        #1;
        chk("t1_ram_wr", ram_wr, 1);
        chk("t1_ram_addr", ram_addr, 5);
        chk("t1_wait_low", av_waitrequest, 0);
        step();
        av_write = 0; av_read = 1;
        #1;
        chk("t1_rd_wait_1st", av_waitrequest, 1);
        chk("t1_ram_rd", ram_rd, 1);
        step();
        #1;
        chk("t1_rd_wait_2nd", av_waitrequest, 0);
        chk("t1_readdata", av_readdata, 32'hDEADBEEF);
        step();
        idle_in();

        // 2: JTAG load address 3 and read
        ta_a = 1; jdo = (38'd3 << 2) | (38'd1 << 34);
        step();
        idle_in();
        #1;
        chk("t2_ram_rd", ram_rd, 1);
        chk("t2_ram_addr", ram_addr, 3);
        chk("t2_ready_low", monitor_ready, 0);
        step();
        #1;
        chk("t2_ready_low2", monitor_ready, 0);
        step();
        #1;
        chk("t2_MonDReg", MonDReg, 32'hA5A50003);
        chk("t2_MonAReg", MonAReg, 4);
        chk("t2_ready", monitor_ready, 1);
        step();

        // 3: JTAG write at 0xFF, address wraps
        ta_a = 1; jdo = 38'(8'hFF) << 2;
        step();
        ta_a = 0; ta_b = 1; jdo = 38'(32'h12345678) << 3;
        step();
        idle_in();
        #1;
        chk("t3_ram_wr", ram_wr, 1);
        chk("t3_ram_addr", ram_addr, 8'hFF);
        chk("t3_ram_wdata", ram_wdata, 32'h12345678);
        chk("t3_ram_be", ram_be, 4'hF);
        step();
        #1;
        chk("t3_MonAReg_wrap", MonAReg, 0);
        chk("t3_ram_content", ram_mem[255], 32'h12345678);
        step();

        // 4: CPU read held while JTAG reads keep coming
        j_gr = 0; c_gr = 0; viol = 0; prev = -1;
        av_read = 1; av_address = 8'h20;
        for (int k = 0; k < 24; k++) begin
            tna_a = monitor_ready;
            #1;
            if (ram_rd) begin
                owner = (ram_addr == 8'h20) ? 0 : 1;
                if (owner == prev) viol++;
                prev = owner;
                if (owner == 1) j_gr++; else c_gr++;
            end
            step();
        end
        idle_in();
        repeat (6) step();
        chk("t4_rr_violations", viol, 0);
        chk("t4_jtag_grants_ge4", j_gr >= 4, 1);
        chk("t4_cpu_grants_ge4", c_gr >= 4, 1);

        // 5: back-to-back no_action strobes
        tna_a = 1;
        #1;
        chk("t5_overrun_before", jtag_overrun, 0);
        step();
        rd_cnt = 0;
        tna_a = 1;
        #1;
        if (ram_rd) rd_cnt++;
        step();
        tna_a = 0;
        for (int k = 0; k < 5; k++) begin
            #1;
            if (ram_rd) rd_cnt++;
            step();
        end
        chk("t5_single_ram_rd", rd_cnt, 1);
        #1;
        chk("t5_overrun_set", jtag_overrun, 1);
        step();
        repeat (3) step();
        #1;
        chk("t5_overrun_sticky", jtag_overrun, 1);
        step();

        // 6: reset inside CPU_RD, then inside JTAG_RD
        av_read = 1; av_address = 8'd7;
        step();
        reset = 1;
        #1;
        chk("t6_rst_cycle_ram_rd", ram_rd, 0);
        chk("t6_rst_cycle_wait", av_waitrequest, 1);
        step();
        reset = 0; idle_in();
        #1;
        chk("t6a_wait", av_waitrequest, 1);
        chk("t6a_MonDReg", MonDReg, 0);
        chk("t6a_ready", monitor_ready, 1);
        chk("t6a_overrun", jtag_overrun, 0);
        chk("t6a_no_strobe", ram_rd | ram_wr, 0);
        step();
        ta_a = 1; jdo = (38'd9 << 2) | (38'd1 << 34);
        step();
        idle_in();
        #1;
        chk("t6b_ram_rd", ram_rd, 1);
        step();
        reset = 1;
        step();
        reset = 0;
        #1;
        chk("t6b_MonDReg", MonDReg, 0);
        chk("t6b_MonAReg", MonAReg, 0);
        chk("t6b_ready", monitor_ready, 1);
        chk("t6b_no_strobe", ram_rd | ram_wr, 0);
        step();

        // random traffic
        cpu_active = 1'b0;
        for (int k = 0; k < 3000; k++) begin
            if (cpu_done) cpu_active = 1'b0;
            if (!cpu_active) begin
                r = $urandom_range(0, 99);
                av_read = 0; av_write = 0;
                if (r < 35) begin
                    av_read = 1; cpu_active = 1'b1;
                    av_address = 8'($urandom);
                end else if (r < 55) begin
                    av_write = 1; cpu_active = 1'b1;
                    av_address = 8'($urandom);
                    av_writedata = $urandom;
                    av_byteenable = 4'($urandom_range(1, 15));
                end
            end
            r = $urandom_range(0, 99);
            ta_a = (r < 5) || (r == 15);
            ta_b = (r >= 5 && r < 10) || (r == 15);
            tna_a = (r >= 10 && r < 15);
            jdo = {6'($urandom), 32'($urandom)};
            reset = ($urandom_range(0, 299) == 0);
            if (reset) begin
                cpu_active = 1'b0;
            end
            step();
            if (reset) begin
                reset = 0;
                av_read = 0; av_write = 0;
            end
        end
        idle_in();
        step();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
